rr_arbiter: RTL and testbench

- Parametrised round-robin arbiter for N requesters that share one downstream resource.
- Issues a registered one-hot grant plus an encoded index and a valid flag.
- Holds each grant until the downstream acknowledges, then rotates priority past the winner.
- Replaces fixed-priority encoding wherever fairness and a grant/ack handshake are required.

---
 rtl/rr_arbiter_pkg.sv | 18 +
 rtl/rr_pick.sv | 47 ++++
 rtl/rr_arbiter.sv | 135 +++++++++++++
 tb/tb_rr_arbiter.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin arbiter.
package rr_arbiter_pkg;

    // Arbiter control state
    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StGrant = 1'b1
    } state_e;

    // Width of an encoded requester index; never narrower than one bit
    function automatic int unsigned idx_width(input int unsigned n);
        if (n <= 1) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request bit at or after ptr,
// wrapping around. Built as a double-width search so the wrap case needs
// no second priority encoder in series.
module rr_pick
    import rr_arbiter_pkg::*;
#(
    parameter  int unsigned N     = 4,
    localparam int unsigned IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     pick,
    output logic [IDX_W-1:0] pick_idx,
    output logic             any
);

    logic [N-1:0]   therm;
    logic [2*N-1:0] dbl;
    logic           found;

    // Thermometer mask of positions >= ptr; lower half of dbl is the masked
    // request, upper half the unmasked request used when nothing sits at or
    // above ptr.
    always_comb begin
        therm = '0;
        for (int i = 0; i < int'(N); i++) begin
            therm[i] = (i >= int'(ptr));
        end
        dbl = {req, req & therm};
    end

    // Lowest set bit of dbl wins; fold its position back into 0..N-1
    always_comb begin
        pick     = '0;
        pick_idx = '0;
        found    = 1'b0;
        for (int j = 0; j < int'(2 * N); j++) begin
            if (!found && dbl[j]) begin
                found             = 1'b1;
                pick[j % int'(N)] = 1'b1;
                pick_idx          = IDX_W'(j % int'(N));
            end
        end
        any = |req;
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant and ack handshake.
// Optional burst hold: define RR_ARB_LOCK_EN to add the lock input, which
// keeps the grant on the current owner across acks.
module rr_arbiter
    import rr_arbiter_pkg::*;
#(
    parameter  int unsigned N     = 4,
    localparam int unsigned IDX_W = idx_width(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             ack,
`ifdef RR_ARB_LOCK_EN
    input  logic             lock,
`endif
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    state_e           state_q, state_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;

    logic [IDX_W-1:0] ptr_adv;
    logic [IDX_W-1:0] pick_ptr;
    logic [N-1:0]     pick;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             hold;
    logic             owner_req;
    logic             rotate;

`ifdef RR_ARB_LOCK_EN
    assign hold = lock;
`else
    assign hold = 1'b0;
`endif

    // Priority pointer one past the current owner, wrapping at N-1
    assign ptr_adv = (gnt_idx_q == IDX_W'(N - 1)) ? '0 : gnt_idx_q + IDX_W'(1);

    // Current owner is still requesting
    assign owner_req = |(req & gnt_q);

    // An unlocked ack rotates priority; ack wins over a same-cycle withdrawal
    assign rotate = (state_q == StGrant) && ack && !hold;

    // On rotation the re-pick searches from the advanced pointer
    assign pick_ptr = rotate ? ptr_adv : ptr_q;

    rr_pick #(
        .N (N)
    ) u_pick (
        .req      (req),
        .ptr      (pick_ptr),
        .pick     (pick),
        .pick_idx (pick_idx),
        .any      (pick_any)
    );

    // Next-state, grant and pointer update
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_idx_d = gnt_idx_q;
        ptr_d     = ptr_q;

        case (state_q)
            StIdle: begin
                // ack is ignored while idle
                if (pick_any) begin
                    state_d   = StGrant;
                    gnt_d     = pick;
                    gnt_idx_d = pick_idx;
                end
            end

            StGrant: begin
                if (rotate) begin
                    ptr_d = ptr_adv;
                    if (pick_any) begin
                        gnt_d     = pick;
                        gnt_idx_d = pick_idx;
                    end else begin
                        state_d   = StIdle;
                        gnt_d     = '0;
                        gnt_idx_d = '0;
                    end
                end else if (!owner_req) begin
                    // Owner withdrew without a rotating ack: release, keep ptr
                    state_d   = StIdle;
                    gnt_d     = '0;
                    gnt_idx_d = '0;
                end
                // Otherwise hold, including a locked ack from a live owner
            end

            default: begin
                state_d   = StIdle;
                gnt_d     = '0;
                gnt_idx_d = '0;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
            ptr_q     <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
            ptr_q     <= ptr_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = (state_q == StGrant);

`ifndef SYNTHESIS
    a_gnt_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));
    a_valid_match : assert property (@(posedge clk) disable iff (rst) gnt_valid == (|gnt_q));
    a_idx_match   : assert property (@(posedge clk) disable iff (rst)
                                     gnt_valid |-> gnt_q[gnt_idx_q]);
`endif

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter (N=4): vector table plus hand sequences.
module tb_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       ack;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
`ifdef RR_ARB_LOCK_EN
    logic       lock;
`endif

    int checks = 0;
    int errors = 0;

    rr_arbiter #(
        .N (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .ack       (ack),
`ifdef RR_ARB_LOCK_EN
        .lock      (lock),
`endif
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       ack;
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       valid;
        string      name;
    } vec_t;

    vec_t vecs[$];

    // Apply inputs for one rising edge, then sample 1 time unit later
    task automatic cycle(input logic r, input logic [3:0] q, input logic a);
        rst = r;
        req = q;
        ack = a;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string name, input logic [3:0] eg,
                             input logic [1:0] ei, input logic ev);
        checks++;
        if (gnt !== eg || gnt_idx !== ei || gnt_valid !== ev) begin
            errors++;
            $display("FAIL %s: got gnt=%b idx=%0d valid=%b, want gnt=%b idx=%0d valid=%b",
                     name, gnt, gnt_idx, gnt_valid, eg, ei, ev);
        end
        checks++;
        if ((gnt_valid !== (|gnt)) || !$onehot0(gnt) ||
            (gnt_valid === 1'b1 && gnt[gnt_idx] !== 1'b1)) begin
            errors++;
            $display("FAIL %s_invariant: got gnt=%b idx=%0d valid=%b, want one-hot-or-zero consistent",
                     name, gnt, gnt_idx, gnt_valid);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req = '0;
        ack = 1'b0;
`ifdef RR_ARB_LOCK_EN
        lock = 1'b0;
`endif

        //               rst  req      ack  gnt      idx  v
        vecs.push_back('{1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, "reset"});
        vecs.push_back('{1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, "single_grant"});
        vecs.push_back('{1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, "single_hold1"});
        vecs.push_back('{1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, "single_hold2"});
        vecs.push_back('{1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, "single_hold3"});
        vecs.push_back('{1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, "single_hold4"});
        vecs.push_back('{1'b0, 4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, "sole_regrant"});
        vecs.push_back('{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, "withdraw_a"});
        vecs.push_back('{1'b0, 4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1, "wrap_skip"});
        vecs.push_back('{1'b0, 4'b0011, 1'b1, 4'b0010, 2'd1, 1'b1, "wrap_next"});
        vecs.push_back('{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, "withdraw_b"});
        vecs.push_back('{1'b0, 4'b0011, 1'b0, 4'b0010, 2'd1, 1'b1, "ptr_kept"});
        vecs.push_back('{1'b0, 4'b1001, 1'b1, 4'b1000, 2'd3, 1'b1, "ack_beats_withdraw"});
        vecs.push_back('{1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, "ack_to_idle"});
        vecs.push_back('{1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, "ack_in_idle"});
        vecs.push_back('{1'b0, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, "rot_0"});
        vecs.push_back('{1'b0, 4'b0101, 1'b0, 4'b0001, 2'd0, 1'b1, "other_bits_ignored"});
        vecs.push_back('{1'b0, 4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, "rot_1"});
        vecs.push_back('{1'b0, 4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1, "rot_2"});
        vecs.push_back('{1'b0, 4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1, "rot_3"});
        vecs.push_back('{1'b0, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, "rot_wrap"});
        vecs.push_back('{1'b1, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, "reset_mid_grant"});
        vecs.push_back('{1'b0, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, "post_reset"});

        cycle(1'b1, 4'b0000, 1'b0);
        cycle(1'b1, 4'b0000, 1'b0);

        foreach (vecs[k]) begin
            cycle(vecs[k].rst, vecs[k].req, vecs[k].ack);
            check_out(vecs[k].name, vecs[k].gnt, vecs[k].idx, vecs[k].valid);
        end

        // Back-to-back rotation over two full laps, no idle bubble
        cycle(1'b1, 4'b0000, 1'b0);
        cycle(1'b0, 4'b1111, 1'b0);
        check_out("lap_start", 4'b0001, 2'd0, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            logic [1:0] ei;
            logic [3:0] eg;
            ei = 2'(i % 4);
            eg = 4'b0001 << ei;
            cycle(1'b0, 4'b1111, 1'b1);
            check_out($sformatf("lap_%0d", i), eg, ei, 1'b1);
        end

        // Ack with reset asserted: reset must win
        cycle(1'b1, 4'b1111, 1'b1);
        check_out("reset_with_ack", 4'b0000, 2'd0, 1'b0);

`ifdef RR_ARB_LOCK_EN
        // Burst hold on requester 0, then release to requester 1
        lock = 1'b1;
        cycle(1'b0, 4'b0011, 1'b0);
        check_out("lock_grant", 4'b0001, 2'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 4'b0011, 1'b1);
            check_out($sformatf("lock_hold_%0d", i), 4'b0001, 2'd0, 1'b1);
        end
        lock = 1'b0;
        cycle(1'b0, 4'b0011, 1'b1);
        check_out("lock_release", 4'b0010, 2'd1, 1'b1);
`endif

        cycle(1'b0, 4'b0000, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
